// File: rtl/csa_pipe_adder.sv
// rtl/csa_pipe_adder.sv - pipelined carry-select adder/subtractor with valid/ready handshakes
//
// Purpose: adds (sub=0: a+b+c_in) or subtracts (sub=1: a+~b+1) two WIDTH-bit
// operands, resolving one SEG-bit segment per pipeline stage. Each stage
// precomputes the segment sum for carry-in 0 and 1 and lets the carry from the
// previous stage pick one. Latency is NSEG cycles; throughput is one op/cycle.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  input handshake for a, b, c_in, sub
//   a, b                 WIDTH-bit operands
//   c_in                 carry-in (ignored when sub=1)
//   sub                  0 = add, 1 = subtract
//   out_valid/out_ready  output handshake for sum, c_out, ovf
//   sum                  WIDTH-bit result
//   c_out                carry out of the MSB (sub mode: 1 = no borrow)
//   ovf                  two's-complement overflow

module csa_pipe_adder #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NSEG = WIDTH / SEG;
    localparam int LAST = NSEG - 1;

    generate
        if (WIDTH % SEG != 0) begin : g_bad_seg
            $error("csa_pipe_adder: WIDTH must be a multiple of SEG");
        end
    endgenerate

    logic             advance;
    logic             accept;

    logic [NSEG-1:0]  valid_q, valid_d;
    logic [NSEG-1:0]  carry_q, carry_d;
    logic [WIDTH-1:0] opa_q [NSEG];
    logic [WIDTH-1:0] opa_d [NSEG];
    logic [WIDTH-1:0] opb_q [NSEG];
    logic [WIDTH-1:0] opb_d [NSEG];
    logic [WIDTH-1:0] res_q [NSEG];
    logic [WIDTH-1:0] res_d [NSEG];

    // Per-stage carry-in, partially resolved result, and the two candidate sums.
    logic [NSEG-1:0]  cin_s;
    logic [WIDTH-1:0] base_s [NSEG];
    logic [SEG:0]     sum0_s [NSEG];
    logic [SEG:0]     sum1_s [NSEG];

    always_comb begin
        advance  = !valid_q[LAST] || out_ready;
        in_ready = advance && !rst;
        accept   = in_valid && in_ready;

        cin_s   = '0;
        valid_d = '0;
        carry_d = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (k == 0) begin
                // Subtract is folded into stage 0: b is inverted once here and
                // the forced carry-in of 1 completes the two's complement.
                opa_d[k]   = a;
                opb_d[k]   = sub ? ~b : b;
                cin_s[k]   = sub ? 1'b1 : c_in;
                base_s[k]  = '0;
                valid_d[k] = accept;
            end else begin
                opa_d[k]   = opa_q[k-1];
                opb_d[k]   = opb_q[k-1];
                cin_s[k]   = carry_q[k-1];
                base_s[k]  = res_q[k-1];
                valid_d[k] = valid_q[k-1];
            end

            sum0_s[k] = {1'b0, opa_d[k][k*SEG +: SEG]} + {1'b0, opb_d[k][k*SEG +: SEG]};
            sum1_s[k] = {1'b0, opa_d[k][k*SEG +: SEG]} + {1'b0, opb_d[k][k*SEG +: SEG]}
                        + {{SEG{1'b0}}, 1'b1};

            res_d[k]                  = base_s[k];
            res_d[k][k*SEG +: SEG]    = cin_s[k] ? sum1_s[k][SEG-1:0] : sum0_s[k][SEG-1:0];
            carry_d[k]                = cin_s[k] ? sum1_s[k][SEG] : sum0_s[k][SEG];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < NSEG; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            for (int k = 0; k < NSEG; k++) begin
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
                res_q[k] <= res_d[k];
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign sum       = res_q[LAST];
    assign c_out     = carry_q[LAST];
    // Carry into the MSB is recovered from the registered final-stage MSB bits
    // (a ^ b' ^ sum); overflow is that carry XOR the carry out.
    assign ovf       = opa_q[LAST][WIDTH-1] ^ opb_q[LAST][WIDTH-1]
                       ^ res_q[LAST][WIDTH-1] ^ carry_q[LAST];

endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb/tb_csa_pipe_adder.sv - directed self-checking bench for csa_pipe_adder

module tb_csa_pipe_adder;

    localparam int W    = 64;
    localparam int NSEG = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
    logic [W-1:0] a, b, sum;

    logic         o_in_valid, o_in_ready, o_c_in, o_sub, o_out_valid, o_out_ready, o_c_out, o_ovf;
    logic [W-1:0] o_a, o_b, o_sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csa_pipe_adder #(.WIDTH(W), .SEG(16)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    csa_pipe_adder #(.WIDTH(W), .SEG(W)) u_one (
        .clk(clk), .rst(rst),
        .in_valid(o_in_valid), .in_ready(o_in_ready),
        .a(o_a), .b(o_b), .c_in(o_c_in), .sub(o_sub),
        .out_valid(o_out_valid), .out_ready(o_out_ready),
        .sum(o_sum), .c_out(o_c_out), .ovf(o_ovf)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One operation with out_ready=1; result must appear exactly NSEG edges after acceptance.
    task automatic run_single(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic vc, input logic vs, input logic [W-1:0] esum,
                              input logic ec, input logic eo);
        @(negedge clk);
        a = va; b = vb; c_in = vc; sub = vs; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, W'(in_ready), W'(1));
        for (int n = 1; n <= NSEG; n++) begin
            @(negedge clk);
            if (n == 1) in_valid = 1'b0;
            if (n < NSEG) begin
                chk({tag, "_early"}, W'(out_valid), W'(0));
            end else begin
                chk({tag, "_valid"}, W'(out_valid), W'(1));
                chk({tag, "_sum"}, sum, esum);
                chk({tag, "_cout"}, W'(c_out), W'(ec));
                chk({tag, "_ovf"}, W'(ovf), W'(eo));
            end
        end
    endtask

    initial begin
        int   issued, got, stall, stale;
        bit   seen, acc_pend;
        logic [W-1:0] held;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        o_in_valid = 1'b0; o_a = '0; o_b = '0; o_c_in = 1'b0; o_sub = 1'b0; o_out_ready = 1'b1;
        #1;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_sum", sum, W'(0));
        chk("rst_cout", W'(c_out), W'(0));
        chk("rst_ovf", W'(ovf), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_single("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        run_single("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                   64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_single("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_single("sub_pos", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
        run_single("segbound", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                   64'h0000_0001_0000_0000, 1'b0, 1'b0);
        run_single("cin", 64'd10, 64'd20, 1'b1, 1'b0, 64'd31, 1'b0, 1'b0);

        // Single-segment instance: latency of one edge.
        @(negedge clk);
        o_a = 64'hFFFF_FFFF_FFFF_FFFF; o_b = 64'd1; o_in_valid = 1'b1;
        @(negedge clk);
        o_in_valid = 1'b0;
        chk("one_valid", W'(o_out_valid), W'(1));
        chk("one_sum", o_sum, W'(0));
        chk("one_cout", W'(o_c_out), W'(1));
        chk("one_ovf", W'(o_ovf), W'(0));
        chk("one_in_ready", W'(o_in_ready), W'(1));

        // Backpressure stream: ops i + 3i, 3-cycle stall once the first result shows.
        issued = 0; got = 0; stall = 0; seen = 0; acc_pend = 0; held = '0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            if (acc_pend) issued++;
            if (out_valid && !seen) begin
                seen  = 1;
                stall = 3;
                held  = sum;
            end
            out_ready = (stall == 0);
            in_valid  = (issued < 6);
            a    = (stall > 0) ? 64'hDEAD_BEEF : W'(issued + 1);
            b    = (stall > 0) ? 64'h1234 : W'(3 * (issued + 1));
            c_in = 1'b0;
            sub  = 1'b0;
            #1;
            if (stall > 0) begin
                chk("bp_in_ready", W'(in_ready), W'(0));
                chk("bp_hold_valid", W'(out_valid), W'(1));
                chk("bp_hold_sum", sum, held);
                stall--;
            end
            acc_pend = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk("bp_result", sum, W'(4 * (got + 1)));
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", W'(got), W'(6));
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("bp_no_dup", W'(stale), W'(0));

        // Reset mid-flight: three ops in the pipe, first result held at the output.
        out_ready = 1'b0;
        @(negedge clk);
        a = 64'd10; b = 64'd20; in_valid = 1'b1;
        @(negedge clk);
        a = 64'd11; b = 64'd21;
        @(negedge clk);
        a = 64'd12; b = 64'd22;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_pre_valid", W'(out_valid), W'(1));
        chk("mid_pre_sum", sum, 64'd30);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", W'(out_valid), W'(0));
        chk("mid_rst_sum", sum, W'(0));
        chk("mid_rst_cout", W'(c_out), W'(0));
        chk("mid_rst_ovf", W'(ovf), W'(0));
        chk("mid_rst_in_ready", W'(in_ready), W'(0));
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("mid_no_stale", W'(stale), W'(0));
        run_single("post_rst", 64'd3, 64'd1, 1'b0, 1'b0, 64'd4, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
